// File: rtl/mac_pkg.sv
// Shared encodings and saturating-add helper for the vector MAC accumulator bank.
package mac_pkg;

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_CLR  = 2'b01,
    OP_LOAD = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ACT_RAW     = 2'b00,
    ACT_RELU    = 2'b01,
    ACT_RELU_SH = 2'b10,
    ACT_RSVD    = 2'b11
  } act_e;

  // Operands are sign-extended to SAT_W; the clamp is applied at the caller's width w (< SAT_W).
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int                      w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] one;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_res_t              r;
    one   = {{SAT_W{1'b0}}, 1'b1};
    sum   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi    = (one <<< (w - 1)) - one;
    lo    = -(one <<< (w - 1));
    r.sat = 1'b0;
    r.val = sum[SAT_W-1:0];
    if (sum > hi) begin
      r.sat = 1'b1;
      r.val = hi[SAT_W-1:0];
    end else if (sum < lo) begin
      r.sat = 1'b1;
      r.val = lo[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_dot_lanes.sv
// Combinational signed dot product of two packed LANES x EW operand words.
module mac_dot_lanes #(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int DW    = 2 * EW + $clog2(LANES)
) (
  input  logic [LANES*EW-1:0] a_i,
  input  logic [LANES*EW-1:0] b_i,
  output logic signed [DW-1:0] dot_o
);

  logic signed [2*EW-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign prod[i] = $signed(a_i[i*EW +: EW]) * $signed(b_i[i*EW +: EW]);
  end

  // NOTE: every variable written in always_comb is assigned before any conditional use, so no latch is inferred.
  always_comb begin
    dot_o = '0;
    for (int i = 0; i < LANES; i++) begin
      dot_o = dot_o + DW'(prod[i]);
    end
  end

endmodule

// File: rtl/mac_vec_acc_bank.sv
// Two-stage pipelined LANES-wide signed MAC into NACC saturating accumulators with activation.
module mac_vec_acc_bank
  import mac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int ACC_W = 32,
  parameter int NACC  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [$clog2(NACC)-1:0]  acc_sel,
  input  logic [1:0]               act_mode,
  input  logic [4:0]               shamt,
  input  logic [LANES*EW-1:0]      rs1,
  input  logic [LANES*EW-1:0]      rs2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_sat,
  output logic [$clog2(NACC)-1:0]  out_sel
);

  localparam int SW = $clog2(NACC);
  localparam int DW = 2 * EW + $clog2(LANES);
  localparam logic [ACC_W-1:0] QMAX = ACC_W'((1 << (EW - 1)) - 1);

  logic signed [DW-1:0] dot;
  logic                 adv;

  logic             s1_valid_q;
  logic [ACC_W-1:0] s1_dot_q;
  op_e              s1_op_q;
  logic [SW-1:0]    s1_sel_q;
  act_e             s1_act_q;
  logic [4:0]       s1_sh_q;

  logic [ACC_W-1:0] acc_q [NACC];
  logic [NACC-1:0]  sat_q;
  logic [ACC_W-1:0] acc_d;
  logic             sat_d;
  logic [ACC_W-1:0] act_d;
  logic [ACC_W-1:0] relu;
  logic [ACC_W-1:0] shifted;
  sat_res_t         mac_res;
  sat_res_t         load_res;
  logic             unused_hi_bits;

  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic             out_sat_q;
  logic [SW-1:0]    out_sel_q;

  mac_dot_lanes #(.LANES(LANES), .EW(EW), .DW(DW)) u_dot (
    .a_i   (rs1),
    .b_i   (rs2),
    .dot_o (dot)
  );

  // Both stages move together; a held output freezes the whole pipe.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dot_q   <= '0;
      s1_op_q    <= OP_READ;
      s1_sel_q   <= '0;
      s1_act_q   <= ACT_RAW;
      s1_sh_q    <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_dot_q <= ACC_W'(dot);
        s1_op_q  <= op_e'(op);
        s1_sel_q <= acc_sel;
        s1_act_q <= act_e'(act_mode);
        s1_sh_q  <= shamt;
      end
    end
  end

  always_comb begin
    mac_res  = sat_add(SAT_W'(signed'(acc_q[s1_sel_q])), SAT_W'(signed'(s1_dot_q)), ACC_W);
    load_res = sat_add('0, SAT_W'(signed'(s1_dot_q)), ACC_W);
    acc_d    = acc_q[s1_sel_q];
    sat_d    = sat_q[s1_sel_q];
    unique case (s1_op_q)
      OP_MAC: begin
        acc_d = mac_res.val[ACC_W-1:0];
        sat_d = sat_q[s1_sel_q] | mac_res.sat;
      end
      OP_CLR: begin
        acc_d = '0;
        sat_d = 1'b0;
      end
      OP_LOAD: begin
        acc_d = load_res.val[ACC_W-1:0];
        sat_d = load_res.sat;
      end
      default: ;
    endcase

    relu    = acc_d[ACC_W-1] ? '0 : acc_d;
    shifted = relu >> s1_sh_q;
    act_d   = acc_d;
    unique case (s1_act_q)
      ACT_RELU:    act_d = relu;
      ACT_RELU_SH: act_d = (shifted > QMAX) ? QMAX : shifted;
      default:     act_d = acc_d;
    endcase
  end

  assign unused_hi_bits = ^{mac_res.val[SAT_W-1:ACC_W], load_res.val[SAT_W-1:ACC_W]};

  // NOTE: the accumulator bank is a flop array, not a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
      sat_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_sel_q   <= '0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc_q[s1_sel_q] <= acc_d;
        sat_q[s1_sel_q] <= sat_d;
        out_data_q      <= act_d;
        out_sat_q       <= sat_d;
        out_sel_q       <= s1_sel_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mac_vec_acc_bank.sv
// Directed self-checking bench for mac_vec_acc_bank with hand-computed expected values.
module tb_mac_vec_acc_bank;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [1:0]  acc_sel;
  logic [1:0]  act_mode;
  logic [4:0]  shamt;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic [1:0]  out_sel;

  int n_pass  = 0;
  int n_total = 0;

  mac_vec_acc_bank #(.LANES(4), .EW(8), .ACC_W(32), .NACC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_sel   (acc_sel),
    .act_mode  (act_mode),
    .shamt     (shamt),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  // Issue one request with out_ready high and wait (bounded) for its result.
  task automatic run_op(input op_e o, input logic [1:0] sel, input act_e am, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic s, output logic [1:0] so, output int lat);
    @(negedge clk);
    op = o; acc_sel = sel; act_mode = am; shamt = sh; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check("op_timeout", 32'(out_valid), 32'd1);
    d  = out_data;
    s  = out_sat;
    so = out_sel;
  endtask

  task automatic expect_op(input string tag, input op_e o, input logic [1:0] sel, input act_e am,
                           input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_s);
    logic [31:0] d;
    logic        s;
    logic [1:0]  so;
    int          lat;
    run_op(o, sel, am, sh, a, b, d, s, so, lat);
    check({tag, "_data"}, d, exp_d);
    check({tag, "_sat"}, 32'(s), 32'(exp_s));
  endtask

  // Interleaved sel0/sel3 MAC stream: selector, operands, hand-computed dot product.
  logic [1:0]  t_sel [6] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
  logic [31:0] t_a   [6] = '{32'h01010101, 32'h05000000, 32'hFF000000,
                             32'h00000010, 32'h7F000000, 32'h000000FE};
  logic [31:0] t_b   [6] = '{32'h02020202, 32'h03000000, 32'h04000000,
                             32'h00000010, 32'h7F000000, 32'h00000003};
  int          t_dot [6] = '{8, 15, -4, 256, 16129, -6};

  initial begin
    logic [31:0] d;
    logic        s;
    logic [1:0]  so;
    int          lat;
    logic [31:0] exp_q [$];
    int          m [4];
    int          idx;
    int          got;
    int          cyc;
    logic        accept;
    logic        consume;
    logic        held;
    logic [31:0] hold_d;
    logic [1:0]  hold_sel;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; acc_sel = 2'd0; act_mode = 2'b00; shamt = 5'd0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // LOAD then MAC on sel0: dot = 4+3+2+1 = 10.
    run_op(OP_LOAD, 2'd0, ACT_RAW, 5'd0, 32'h01020304, 32'h01010101, d, s, so, lat);
    check("load_latency", 32'(lat), 32'd2);
    check("load_data", d, 32'd10);
    check("load_sel", 32'(so), 32'd0);
    expect_op("mac_sel0", OP_MAC, 2'd0, ACT_RAW, 5'd0, 32'h01020304, 32'h01010101, 32'd20, 1'b0);

    // sel1: lane0 -128*127 = -16256.
    expect_op("relu_neg", OP_MAC, 2'd1, ACT_RELU, 5'd0, 32'h00000080, 32'h0000007F, 32'd0, 1'b0);
    expect_op("read_raw", OP_READ, 2'd1, ACT_RAW, 5'd0, 32'h0, 32'h0, 32'hFFFFC080, 1'b0);
    expect_op("read_m10neg", OP_READ, 2'd1, ACT_RELU_SH, 5'd0, 32'h0, 32'h0, 32'd0, 1'b0);
    expect_op("read_rsvd", OP_READ, 2'd1, ACT_RSVD, 5'd0, 32'h0, 32'h0, 32'hFFFFC080, 1'b0);

    // Saturation on sel2: 32767 streamed MACs of dot 65536 reach 0x7FFF0000.
    @(negedge clk);
    op = OP_MAC; acc_sel = 2'd2; act_mode = ACT_RAW; rs1 = 32'h80808080; rs2 = 32'h80808080;
    in_valid = 1'b1;
    repeat (32767) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    expect_op("sat_pre", OP_MAC, 2'd2, ACT_RAW, 5'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFC04, 1'b0);
    expect_op("sat_hit", OP_MAC, 2'd2, ACT_RAW, 5'd0, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFFFF, 1'b1);
    expect_op("sat_sticky", OP_MAC, 2'd2, ACT_RAW, 5'd0, 32'h80808080, 32'h7F7F7F7F, 32'h7FFF01FF, 1'b1);
    expect_op("clr_sel2", OP_CLR, 2'd2, ACT_RAW, 5'd0, 32'h0, 32'h0, 32'd0, 1'b0);

    // Interleaved stream with a 3-cycle output stall.
    m[0] = 20; m[1] = 0; m[2] = 0; m[3] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    idx = 0; got = 0; cyc = 0; held = 1'b0; hold_d = '0; hold_sel = '0;
    op = OP_MAC; act_mode = ACT_RAW; acc_sel = t_sel[0]; rs1 = t_a[0]; rs2 = t_b[0]; in_valid = 1'b1;
    while (got < 6 && cyc < 40) begin
      out_ready = (cyc >= 3 && cyc < 6) ? 1'b0 : 1'b1;
      #1;
      accept  = in_valid & in_ready;
      consume = out_valid & out_ready;
      if (!out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (!held) begin
          held = 1'b1; hold_d = out_data; hold_sel = out_sel;
        end else begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", out_data, hold_d);
          check("stall_sel", 32'(out_sel), 32'(hold_sel));
        end
      end
      if (consume) begin
        if (exp_q.size() == 0) check("stream_extra", 32'(got), 32'd99);
        else check("stream_data", out_data, exp_q.pop_front());
        got++;
      end
      if (accept) begin
        m[t_sel[idx]] = m[t_sel[idx]] + t_dot[idx];
        exp_q.push_back(32'(m[t_sel[idx]]));
      end
      @(posedge clk); #1;
      if (accept) begin
        idx++;
        if (idx < 6) begin
          acc_sel = t_sel[idx]; rs1 = t_a[idx]; rs2 = t_b[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    check("stream_count", 32'(got), 32'd6);
    check("stream_stalled", 32'(held), 32'd1);
    expect_op("final_sel0", OP_READ, 2'd0, ACT_RAW, 5'd0, 32'h0, 32'h0, 32'd16153, 1'b0);
    expect_op("final_sel3", OP_READ, 2'd3, ACT_RAW, 5'd0, 32'h0, 32'h0, 32'd265, 1'b0);

    // Mode 10: 5000>>4 = 312 clamps to 127; 1000>>4 = 62.
    expect_op("m10_clamp", OP_LOAD, 2'd1, ACT_RELU_SH, 5'd4, 32'h00002F7F, 32'h00000127, 32'd127, 1'b0);
    expect_op("m10_shift", OP_LOAD, 2'd1, ACT_RELU_SH, 5'd4, 32'h00000064, 32'h0000000A, 32'd62, 1'b0);
    expect_op("relu_pos", OP_READ, 2'd1, ACT_RELU, 5'd0, 32'h0, 32'h0, 32'd1000, 1'b0);

    // Reset with two ops in flight.
    @(negedge clk);
    op = OP_LOAD; act_mode = ACT_RAW; acc_sel = 2'd0; rs1 = 32'h7F7F7F7F; rs2 = 32'h01010101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_sel = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_op($sformatf("post_rst_sel%0d", i), OP_READ, 2'(i), ACT_RAW, 5'd0, 32'h0, 32'h0, 32'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
